// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared types and constants for the 4x4 FFT tile datapath
// Purpose:
//   complex_t / tile_t element types, tile dimension, default fixed-point
//   fraction width, 32-bit saturation bounds and the 32-bit reduction helper
//   used by both the complex multiplier and the tile accumulator.
// Configuration macro:
//   FFT_TILE_CMAC_SATURATE_EN - when defined, reduce32 saturates to
//   [SAT_MIN, SAT_MAX]; otherwise it wraps (two's-complement truncation).
package fft_pkg;

  localparam int TILE_DIM          = 4;
  localparam int DEFAULT_FRAC_BITS = 16;

  localparam logic [31:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_MIN = 32'h8000_0000;

  typedef struct packed {
    logic signed [31:0] r;
    logic signed [31:0] i;
  } complex_t;

  typedef complex_t [0:TILE_DIM-1][0:TILE_DIM-1] tile_t;

  // Brings a wide signed intermediate back to a 32-bit field.
  function automatic logic signed [31:0] reduce32(input logic signed [64:0] v);
`ifdef FFT_TILE_CMAC_SATURATE_EN
    if (v > $signed({33'd0, SAT_MAX})) begin
      return SAT_MAX;
    end
    if (v < $signed({{33{1'b1}}, SAT_MIN})) begin
      return SAT_MIN;
    end
    return v[31:0];
`else
    return v[31:0];
`endif
  endfunction

endpackage

// File: rtl/complex_mult.sv
// rtl/complex_mult.sv - one registered fixed-point complex multiply
// Purpose:
//   o_p <= reduce32(((a*b) full precision) >>> FRAC_BITS) per field, captured
//   only when i_en is high so the product holds between valid tiles.
// Ports:
//   clk    in   clock
//   reset  in   asynchronous active-low reset (clears the product)
//   i_en   in   capture enable
//   i_a    in   complex_t multiplicand (image spectrum element)
//   i_b    in   complex_t multiplier (kernel spectrum element)
//   o_p    out  complex_t registered product
// Configuration macro:
//   FFT_TILE_CMAC_SATURATE_EN - selects saturating instead of wrapping reduction.
module complex_mult
  import fft_pkg::*;
#(
  parameter int FRAC_BITS = DEFAULT_FRAC_BITS
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     i_en,
  input  complex_t i_a,
  input  complex_t i_b,
  output complex_t o_p
);

  logic signed [63:0] w_ac;
  logic signed [63:0] w_bd;
  logic signed [63:0] w_ad;
  logic signed [63:0] w_bc;
  logic signed [64:0] w_re;
  logic signed [64:0] w_im;
  complex_t           r_p;

  // Operands are sign-extended to 64 bits before multiplying so the
  // partial products keep full precision.
  assign w_ac = 64'(i_a.r) * 64'(i_b.r);
  assign w_bd = 64'(i_a.i) * 64'(i_b.i);
  assign w_ad = 64'(i_a.r) * 64'(i_b.i);
  assign w_bc = 64'(i_a.i) * 64'(i_b.r);

  // One extra bit so the add/subtract of two 64-bit products cannot overflow.
  assign w_re = 65'(w_ac) - 65'(w_bd);
  assign w_im = 65'(w_ad) + 65'(w_bc);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_p <= '0;
    end else if (i_en) begin
      // Arithmetic shift truncates toward -inf.
      r_p.r <= reduce32(w_re >>> FRAC_BITS);
      r_p.i <= reduce32(w_im >>> FRAC_BITS);
    end
  end

  assign o_p = r_p;

endmodule

// File: rtl/fft_tile_cmac.sv
// rtl/fft_tile_cmac.sv - frequency-domain tile multiply-accumulate over channels
// Purpose:
//   Multiplies each incoming 4x4 FFT tile element-wise by the matching kernel
//   spectrum tile (read from a tile-wide synchronous memory) and accumulates
//   the products over NUM_CHANNELS consecutive tiles, emitting one summed tile.
//   Pipeline: T capture tile/tags, T+1 products, T+2 accumulate, out_valid at T+3.
// Ports:
//   clk                  in   clock
//   reset                in   asynchronous active-low reset
//   in_valid             in   in_tile valid this cycle
//   in_tile              in   tile_t FFT output tile
//   kern_base            in   kernel tile-set base address, sampled on channel 0
//   kernel_read_address  out  kernel memory address (combinational)
//   kernel_tile          in   tile_t kernel memory data, 1-cycle read latency
//   out_valid            out  one-cycle pulse, out_tile holds a completed sum
//   out_tile             out  tile_t accumulated tile, held until next out_valid
//   busy                 out  channel count nonzero or pipeline occupied
// Configuration macro:
//   FFT_TILE_CMAC_SATURATE_EN - saturating product reduction and accumulation.
module fft_tile_cmac
  import fft_pkg::*;
#(
  parameter int NUM_CHANNELS = 3,
  parameter int FRAC_BITS    = DEFAULT_FRAC_BITS,
  parameter int ADDR_WIDTH   = 13
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  tile_t                 in_tile,
  input  logic [ADDR_WIDTH-1:0] kern_base,
  output logic [ADDR_WIDTH-1:0] kernel_read_address,
  input  tile_t                 kernel_tile,
  output logic                  out_valid,
  output tile_t                 out_tile,
  output logic                  busy
);

  // A single-channel build still needs a 1-bit counter to keep widths legal.
  localparam int CNT_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [CNT_W-1:0] LAST_CH = CNT_W'(NUM_CHANNELS - 1);

  logic [CNT_W-1:0]      r_ch_cnt;
  logic [ADDR_WIDTH-1:0] r_base_q;
  logic                  w_ch_first;
  logic                  w_ch_last;

  // Stage 1: captured tile and channel tags
  tile_t r_tile_q;
  logic  r_s1_valid;
  logic  r_s1_first;
  logic  r_s1_last;

  // Stage 2: registered products (inside complex_mult) and tags
  tile_t w_prod;
  logic  r_s2_valid;
  logic  r_s2_first;
  logic  r_s2_last;

  // Stage 3: accumulator and output
  tile_t r_acc;
  tile_t w_acc_next;
  tile_t r_out_tile;
  logic  r_out_valid;

  assign w_ch_first = (r_ch_cnt == '0);
  assign w_ch_last  = (r_ch_cnt == LAST_CH);

  // On channel 0 the live kern_base is used so the first kernel tile is read
  // in the same cycle the base is latched.
  assign kernel_read_address = (w_ch_first ? kern_base : r_base_q) + ADDR_WIDTH'(r_ch_cnt);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ch_cnt <= '0;
      r_base_q <= '0;
    end else if (in_valid) begin
      if (w_ch_first) begin
        r_base_q <= kern_base;
      end
      r_ch_cnt <= w_ch_last ? '0 : r_ch_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_valid <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
      r_tile_q   <= '0;
    end else begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_tile_q   <= in_tile;
        r_s1_first <= w_ch_first;
        r_s1_last  <= w_ch_last;
      end
    end
  end

  // kernel_tile for this tile arrives one cycle after its address, which lines
  // up with r_tile_q.
  for (genvar gi = 0; gi < TILE_DIM; gi++) begin : g_row
    for (genvar gj = 0; gj < TILE_DIM; gj++) begin : g_col
      complex_mult #(
        .FRAC_BITS(FRAC_BITS)
      ) u_cmult (
        .clk  (clk),
        .reset(reset),
        .i_en (r_s1_valid),
        .i_a  (r_tile_q[gi][gj]),
        .i_b  (kernel_tile[gi][gj]),
        .o_p  (w_prod[gi][gj])
      );
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s2_valid <= 1'b0;
      r_s2_first <= 1'b0;
      r_s2_last  <= 1'b0;
    end else begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_first <= r_s1_first;
        r_s2_last  <= r_s1_last;
      end
    end
  end

  // The first channel overwrites rather than adds, so no explicit clear of the
  // accumulator is needed between output tiles.
  always_comb begin
    w_acc_next = r_acc;
    for (int i = 0; i < TILE_DIM; i++) begin
      for (int j = 0; j < TILE_DIM; j++) begin
        if (r_s2_first) begin
          w_acc_next[i][j] = w_prod[i][j];
        end else begin
          w_acc_next[i][j].r = reduce32(65'(r_acc[i][j].r) + 65'(w_prod[i][j].r));
          w_acc_next[i][j].i = reduce32(65'(r_acc[i][j].i) + 65'(w_prod[i][j].i));
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc       <= '0;
      r_out_tile  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_s2_valid & r_s2_last;
      if (r_s2_valid) begin
        r_acc <= w_acc_next;
        if (r_s2_last) begin
          r_out_tile <= w_acc_next;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_tile  = r_out_tile;
  assign busy      = (r_ch_cnt != '0) | r_s1_valid | r_s2_valid;

endmodule
